adc128s_resp: RTL and testbench

Synthesizable SPI responder that emulates the ADC128S 8-channel, 12-bit A2D converter. It is the far end of the A2D SPI link, so the A2D interface can be exercised on hardware, or in fast RTL benches, without the behavioral converter model. Each channel's conversion value comes from a 12-bit input slice. The block follows the converter's two-phase protocol: the channel address written in one transaction selects the data returned in the next transaction.

---
 rtl/adc128s_resp_if.sv | 11 +
 rtl/adc128s_resp.sv | 100 ++++++++++
 tb/tb_adc128s_resp.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/adc128s_resp_if.sv
// SPI pins of the ADC128S link; the master drives select, clock and data,
// the responder drives MISO.
interface adc128s_resp_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/adc128s_resp.sv
// ADC128S SPI responder: returns the channel addressed by the previous
// complete transaction and latches the newly addressed channel at its end.
module adc128s_resp (
  input  logic                 clk,
  input  logic                 rst_n,
  adc128s_resp_if.slave        spi,
  input  logic [95:0]          chan_data,
  output logic [2:0]           chnnl,
  output logic                 xfer_done,
  output logic                 frame_err
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [2:0]  ss_sync;
  logic [2:0]  sclk_sync;
  logic [1:0]  mosi_sync;
  logic        ss_fall;
  logic        ss_rise;
  logic        sclk_rise;
  logic        sclk_fall;
  logic [0:0]  state;
  logic [15:0] tx_shft;
  logic [15:0] rx_shft;
  logic [4:0]  rise_cnt;

  // NOTE: the synchronizers are left out of reset on purpose: if they were
  // forced high, an SS_n still low at reset release would look like a fresh
  // falling edge and start a bogus transaction.
  always_ff @(posedge clk) begin
    ss_sync   <= {ss_sync[1:0], spi.SS_n};
    sclk_sync <= {sclk_sync[1:0], spi.SCLK};
    mosi_sync <= {mosi_sync[0], spi.MOSI};
  end

  // Registered edge strobes; the FSM acts one clk after detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ss_fall   <= 1'b0;
      ss_rise   <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
    end else begin
      ss_fall   <= ss_sync[2] & ~ss_sync[1];
      ss_rise   <= ~ss_sync[2] & ss_sync[1];
      sclk_rise <= ~sclk_sync[2] & sclk_sync[1];
      sclk_fall <= sclk_sync[2] & ~sclk_sync[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx_shft   <= '0;
      rx_shft   <= '0;
      rise_cnt  <= '0;
      chnnl     <= '0;
      xfer_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      xfer_done <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall) begin
            state    <= ACTIVE;
            tx_shft  <= {4'h0, chan_data[12*chnnl +: 12]};
            rx_shft  <= '0;
            rise_cnt <= '0;
          end
        end
        default: begin
          if (ss_rise) begin
            state <= IDLE;
            if (rise_cnt == 5'd16) begin
              chnnl     <= rx_shft[13:11];
              xfer_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            if (sclk_rise) begin
              rx_shft <= {rx_shft[14:0], mosi_sync[1]};
              if (rise_cnt != 5'd17)
                rise_cnt <= rise_cnt + 5'd1;
            end
            // The idle-high SCLK falls once before the first rise; that
            // fall must not consume bit 15.
            if (sclk_fall && rise_cnt != 5'd0)
              tx_shft <= {tx_shft[14:0], 1'b0};
          end
        end
      endcase
    end
  end

  assign spi.MISO = (state == ACTIVE) ? tx_shft[15] : 1'b0;

endmodule

// File: tb/tb_adc128s_resp.sv
// Scoreboard bench for adc128s_resp: an SPI master issues directed frames and
// a monitor checks every xfer_done/frame_err pulse against queued expectations.
module tb_adc128s_resp;

  typedef struct {
    bit          is_done;
    logic [15:0] word;
    logic [2:0]  chnnl;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [95:0] chan_data;
  logic [2:0]  chnnl;
  logic        xfer_done;
  logic        frame_err;
  logic [15:0] master_word;
  exp_t        sb[$];
  int          n_cmp;
  int          n_fail;

  adc128s_resp_if bus ();

  adc128s_resp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi       (bus),
    .chan_data (chan_data),
    .chnnl     (chnnl),
    .xfer_done (xfer_done),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_frame(input bit is_done, input logic [15:0] word, input logic [2:0] ch);
    exp_t e;
    e.is_done = is_done;
    e.word    = word;
    e.chnnl   = ch;
    sb.push_back(e);
  endtask

  // SPI mode-3 style master at clk/32; samples MISO just before each rise.
  task automatic spi_xfer(input logic [15:0] tx, input int n_rises, input bit end_frame,
                          input int mod_rise, input logic [11:0] mod_val);
    logic [15:0] rx;
    rx = '0;
    bus.SS_n = 1'b0;
    repeat (8) @(posedge clk);
    for (int i = 0; i < n_rises; i++) begin
      bus.SCLK = 1'b0;
      bus.MOSI = (i < 16) ? tx[15-i] : 1'b0;
      repeat (16) @(posedge clk);
      rx = {rx[14:0], bus.MISO};
      bus.SCLK = 1'b1;
      repeat (16) @(posedge clk);
      if (i == mod_rise) chan_data[84 +: 12] = mod_val;
    end
    master_word = rx;
    if (end_frame) begin
      repeat (8) @(posedge clk);
      bus.SS_n = 1'b1;
      repeat (10) @(posedge clk);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d expected pulses never seen", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (xfer_done || frame_err) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_pulse: xfer_done=%b frame_err=%b chnnl=%0d", xfer_done, frame_err, chnnl);
        end else begin
          e = sb.pop_front();
          check("pulse_kind_done", {31'd0, xfer_done}, {31'd0, e.is_done});
          check("pulse_kind_err", {31'd0, frame_err}, {31'd0, !e.is_done});
          check("chnnl", {29'd0, chnnl}, {29'd0, e.chnnl});
          if (e.is_done) check("miso_word", {16'd0, master_word}, {16'd0, e.word});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    bus.SS_n = 1'b1;
    bus.SCLK = 1'b1;
    bus.MOSI = 1'b0;
    master_word = '0;
    chan_data = {12'h0FF, 12'h987, 12'h123, 12'h654, 12'h789, 12'h321, 12'h456, 12'hABC};
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_miso", {31'd0, bus.MISO}, 32'd0);
    check("reset_chnnl", {29'd0, chnnl}, 32'd0);
    check("reset_xfer_done", {31'd0, xfer_done}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    repeat (100) @(posedge clk);

    // First transaction: returns ch0, addresses ch5.
    expect_frame(1'b1, 16'h0ABC, 3'd5);
    spi_xfer(16'h2800, 16, 1'b1, -1, 12'h000);
    wait_drain();

    // Second: returns ch5, addresses ch7.
    expect_frame(1'b1, 16'h0123, 3'd7);
    spi_xfer(16'h3800, 16, 1'b1, -1, 12'h000);
    wait_drain();

    // Aborted after 8 rises: chnnl stays 7.
    expect_frame(1'b0, 16'h0000, 3'd7);
    spi_xfer(16'h0800, 8, 1'b1, -1, 12'h000);
    wait_drain();

    // ch7 changes mid-frame; the loaded word is unaffected.
    expect_frame(1'b1, 16'h00FF, 3'd7);
    spi_xfer(16'h3800, 16, 1'b1, 3, 12'hFFF);
    wait_drain();

    expect_frame(1'b1, 16'h0FFF, 3'd1);
    spi_xfer(16'h0800, 16, 1'b1, -1, 12'h000);
    wait_drain();

    // 17 rises (counter saturation) and 0 rises are both frame errors.
    expect_frame(1'b0, 16'h0000, 3'd1);
    spi_xfer(16'h2000, 17, 1'b1, -1, 12'h000);
    wait_drain();
    expect_frame(1'b0, 16'h0000, 3'd1);
    spi_xfer(16'h2000, 0, 1'b1, -1, 12'h000);
    wait_drain();

    expect_frame(1'b1, 16'h0456, 3'd2);
    spi_xfer(16'h1000, 16, 1'b1, -1, 12'h000);
    wait_drain();

    // Reset after 6 rises with SS_n held low through release.
    spi_xfer(16'h1800, 6, 1'b0, -1, 12'h000);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midreset_miso", {31'd0, bus.MISO}, 32'd0);
    check("midreset_chnnl", {29'd0, chnnl}, 32'd0);
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("released_low_miso", {31'd0, bus.MISO}, 32'd0);
    bus.SS_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("after_abort_chnnl", {29'd0, chnnl}, 32'd0);

    expect_frame(1'b1, 16'h0ABC, 3'd3);
    spi_xfer(16'h1800, 16, 1'b1, -1, 12'h000);
    wait_drain();

    // Ignored bits [15:14] and [10:0] all set; address field is 0.
    expect_frame(1'b1, 16'h0789, 3'd0);
    spi_xfer(16'hC7FF, 16, 1'b1, -1, 12'h000);
    wait_drain();

    repeat (20) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
